// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: APB initiator. Accepts one command at a time on a
// valid/ready port and runs it as an APB SETUP/ACCESS transfer. It handles
// slave wait states and an optional wait-state timeout, and reports the
// result on a one-cycle response pulse. All outputs are registered.
`timescale 1ns/1ps
module apb_master_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    // With TIMEOUT=0 the counter is unused; keep it one bit wide so it is legal.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_timeout_hit;

    logic                r_cmd_ready,   w_cmd_ready;
    logic                r_rsp_valid,   w_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata,   w_rsp_rdata;
    logic                r_rsp_error,   w_rsp_error;
    logic                r_rsp_timeout, w_rsp_timeout;
    logic [ADDR_W-1:0]   r_paddr,       w_paddr;
    logic                r_psel,        w_psel;
    logic                r_penable,     w_penable;
    logic                r_pwrite,      w_pwrite;
    logic [DATA_W-1:0]   r_pwdata,      w_pwdata;

    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_error   = r_rsp_error;
    assign rsp_timeout = r_rsp_timeout;
    assign PADDR       = r_paddr;
    assign PSEL        = r_psel;
    assign PENABLE     = r_penable;
    assign PWRITE      = r_pwrite;
    assign PWDATA      = r_pwdata;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; every output is computed here and registered below.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = 1'b0;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_error   = r_rsp_error;
        w_rsp_timeout = r_rsp_timeout;
        w_paddr       = r_paddr;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_pwdata      = r_pwdata;

        unique case (r_state)
            ST_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_paddr     = cmd_addr;
                    w_pwrite    = cmd_write;
                    w_pwdata    = cmd_wdata;
                    w_psel      = 1'b1;
                    w_cmd_ready = 1'b0;
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_penable   = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                // PREADY takes priority over a timeout expiring in the same cycle.
                if (PREADY) begin
                    w_rsp_rdata   = r_pwrite ? '0 : PRDATA;
                    w_rsp_error   = PSLVERR;
                    w_rsp_timeout = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_cmd_ready   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (w_timeout_hit) begin
                    w_rsp_rdata   = '0;
                    w_rsp_error   = 1'b0;
                    w_rsp_timeout = 1'b1;
                    w_rsp_valid   = 1'b1;
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_cmd_ready   = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output and wait-counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_paddr       <= '0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_error   <= w_rsp_error;
            r_rsp_timeout <= w_rsp_timeout;
            r_paddr       <= w_paddr;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_pwdata      <= w_pwdata;
        end
    end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// tb_apb_master_ctrl: directed bench for apb_master_ctrl with a simple APB
// slave model and a response scoreboard queue.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

    localparam int TMO = 4;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    apb_master_ctrl #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Slave model configuration, set per transfer by the stimulus.
    int          slv_waits = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    logic        slv_hang  = 1'b0;
    logic        slv_echo  = 1'b0;
    int          acc_cnt   = 0;

    // Slave: PREADY after slv_waits ACCESS cycles; junk PRDATA/PSLVERR while not ready.
    always @(negedge PCLK) begin
        if (PSEL && PENABLE) begin
            PREADY = !slv_hang && (acc_cnt >= slv_waits);
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            acc_cnt = 0;
        end
        PRDATA  = PREADY ? (slv_echo ? ~PADDR : slv_rdata) : 32'hDEAD_BEEF;
        PSLVERR = PREADY ? slv_err : 1'b1;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare the current response against the oldest scoreboard entry.
    task automatic check_rsp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_rdata"},   rsp_rdata,   e.rdata);
            chk({tag, "_error"},   rsp_error,   e.err);
            chk({tag, "_timeout"}, rsp_timeout, e.tmo);
        end
    endtask

    // One command, checked for protocol sequence, latency and response.
    task automatic do_cmd(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int waits,
                          input logic [31:0] rd, input logic err, input logic hang);
        exp_t e;
        int   exp_lat;
        int   lat;
        int   wt;
        slv_waits = waits;
        slv_rdata = rd;
        slv_err   = err;
        slv_hang  = hang;
        slv_echo  = 1'b0;
        e.tmo     = hang;
        e.err     = hang ? 1'b0 : err;
        e.rdata   = (w || hang) ? 32'h0 : rd;
        exp_lat   = hang ? (TMO + 1) : (2 + waits);
        sb.push_back(e);

        @(negedge PCLK);
        wt = 0;
        while (!cmd_ready && wt < 50) begin
            @(negedge PCLK);
            wt++;
        end
        chk({tag, "_idle_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge PCLK);
        #1;
        // Scramble command inputs so any late sampling shows up on the bus.
        cmd_valid = 1'b0;
        cmd_write = ~w;
        cmd_addr  = ~a;
        cmd_wdata = ~d;
        chk({tag, "_setup_psel"},    PSEL,      1);
        chk({tag, "_setup_penable"}, PENABLE,   0);
        chk({tag, "_setup_pwrite"},  PWRITE,    w);
        chk({tag, "_setup_paddr"},   PADDR,     a);
        chk({tag, "_setup_ready"},   cmd_ready, 0);

        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge PCLK);
            #1;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            chk({tag, "_access_sel_en"}, {PSEL, PENABLE}, 2'b11);
            chk({tag, "_access_paddr"},  PADDR,  a);
            chk({tag, "_access_pwdata"}, PWDATA, d);
        end
        chk({tag, "_latency"}, lat, exp_lat);
        check_rsp(tag);
        chk({tag, "_rsp_psel"},    PSEL,      0);
        chk({tag, "_rsp_penable"}, PENABLE,   0);
        chk({tag, "_rsp_ready"},   cmd_ready, 1);

        @(posedge PCLK);
        #1;
        chk({tag, "_pulse_1cyc"},  rsp_valid, 0);
        chk({tag, "_rdata_held"},  rsp_rdata, e.rdata);
        chk({tag, "_paddr_held"},  PADDR,     a);
    endtask

    logic [31:0] b2b_addr[3];
    int          n_acc;
    int          n_rsp;
    logic        acc_now;

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // Reset state
        repeat (3) @(negedge PCLK);
        chk("rst_cmd_ready",   cmd_ready,   1);
        chk("rst_psel",        PSEL,        0);
        chk("rst_penable",     PENABLE,     0);
        chk("rst_pwrite",      PWRITE,      0);
        chk("rst_paddr",       PADDR,       0);
        chk("rst_pwdata",      PWDATA,      0);
        chk("rst_rsp_valid",   rsp_valid,   0);
        chk("rst_rsp_rdata",   rsp_rdata,   0);
        chk("rst_rsp_error",   rsp_error,   0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        PRESETn = 1'b1;

        // Zero-wait write
        do_cmd("t1_wr", 1'b1, 32'h02, 32'h55, 0, 32'h77, 1'b0, 1'b0);
        // Read with two wait states
        do_cmd("t2_rd", 1'b0, 32'h03, 32'h0, 2, 32'hA5, 1'b0, 1'b0);
        // Slave never ready: timeout after TMO ACCESS cycles
        do_cmd("t3_to", 1'b0, 32'h04, 32'h0, 0, 32'h66, 1'b0, 1'b1);
        // Slave error on a read, then a clean write
        do_cmd("t4_err", 1'b0, 32'h05, 32'h0, 1, 32'h3C, 1'b1, 1'b0);
        do_cmd("t4_ok",  1'b1, 32'h06, 32'h99, 0, 32'h0, 1'b0, 1'b0);

        // Three reads with cmd_valid held high; slave echoes ~PADDR
        slv_waits   = 0;
        slv_err     = 1'b0;
        slv_hang    = 1'b0;
        slv_echo    = 1'b1;
        b2b_addr[0] = 32'h10;
        b2b_addr[1] = 32'h20;
        b2b_addr[2] = 32'h30;
        n_acc       = 0;
        n_rsp       = 0;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = b2b_addr[0];
        cmd_wdata = 32'h0;
        for (int cyc = 0; cyc < 60 && n_rsp < 3; cyc++) begin
            chk("b2b_no_overlap", 32'(cmd_ready && PSEL), 32'd0);
            if (rsp_valid) begin
                check_rsp("b2b");
                n_rsp++;
            end
            acc_now = 1'b0;
            if (cmd_ready && cmd_valid) begin
                exp_t e;
                e.rdata = ~b2b_addr[n_acc];
                e.err   = 1'b0;
                e.tmo   = 1'b0;
                sb.push_back(e);
                n_acc++;
                acc_now = 1'b1;
            end
            @(posedge PCLK);
            #1;
            if (acc_now) begin
                chk("b2b_accept_paddr", PADDR, b2b_addr[n_acc-1]);
                if (n_acc < 3) begin
                    cmd_addr = b2b_addr[n_acc];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        slv_echo  = 1'b0;
        chk("b2b_accepts",   n_acc, 3);
        chk("b2b_responses", n_rsp, 3);

        // Reset asserted in the middle of ACCESS
        slv_hang  = 1'b1;
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h44;
        cmd_wdata = 32'h12;
        @(posedge PCLK);
        #1;
        cmd_valid = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        chk("rstmid_in_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        #1;
        chk("rstmid_psel",      PSEL,      0);
        chk("rstmid_penable",   PENABLE,   0);
        chk("rstmid_cmd_ready", cmd_ready, 1);
        @(negedge PCLK);
        PRESETn  = 1'b1;
        slv_hang = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge PCLK);
            #1;
            chk("rstmid_no_rsp", rsp_valid, 0);
        end
        chk("rstmid_sb_empty", sb.size(), 0);
        do_cmd("t6_after", 1'b0, 32'h08, 32'h0, 1, 32'hC3, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
